pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Parametrised reset/lock sequencer placed beside a PLL in each board clock-gen wrapper. It drives the PLL reset and monitors its lock signal, qualifying lock through a synchroniser and a stability filter. Once lock is qualified it releases NUM_RST reset domains in a staggered order and signals readiness. Lock loss is detected, counted and can optionally trigger automatic PLL re-lock, which the fixed single-reset stretcher never did.

Parameters:
NUM_RST, 4, number of reset outputs (>=1)
RST_CYCLES, 10, hold cycles after lock qualified, before first release (>=1)
STAGGER, 4, cycles between consecutive channel releases (>=1)
LOCK_FILTER, 16, consecutive cycles sync'd lock must stay high to qualify (>=1)
PLL_RST_CYCLES, 8, o_pll_rst pulse length (>=1)
SYNC_STAGES, 2, flops in i_locked synchroniser (>=2)
AUTO_RELOCK, 1, 1: lock loss re-pulses PLL reset; 0: wait for lock only
CNT_W, 8, width of loss counter

Ports:
i_clk  in  1  sequencer clock (free-running, PLL-independent)
i_rst  in  1  synchronous active-high reset
i_locked  in  1  PLL lock, asynchronous to i_clk
o_pll_rst  out  1  PLL reset request, active high
o_rst  out  NUM_RST  per-domain reset, active high, bit 0 released first
o_ready  out  1  all domains released, lock stable
o_loss_cnt  out  CNT_W  saturating count of lock losses after release began

Behaviour:
- One clock (i_clk); reset is synchronous and active-high (i_rst). All outputs are registered.
- Reset values: o_pll_rst=1, o_rst=all ones, o_ready=0, o_loss_cnt=0, state=PLL_RST, synchroniser flops=0.
- i_rst high in any state: the next edge forces the reset values. Resets issued mid-sequence behave identically.
- lock_s is i_locked after SYNC_STAGES flops. All decisions use lock_s only.
- States:
  - PLL_RST: o_pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: o_pll_rst=0. Stay until lock_s=1, then go to FILTER.
  - FILTER: lock_s must be 1 for LOCK_FILTER consecutive cycles, then go to HOLD. If lock_s=0, go to WAIT_LOCK with no count increment.
  - HOLD: lasts RST_CYCLES cycles, then go to RELEASE.
  - RELEASE: on entry cycle, o_rst[0]=0. Each further o_rst[k] clears STAGGER*k cycles after entry. Released bits stay 0. On the cycle o_rst[NUM_RST-1] clears, o_ready=1 and state goes to RUN.
  - RUN: hold all outputs.
- In WAIT_LOCK, FILTER and HOLD, all o_rst=1 and o_ready=0.
- Lock loss (lock_s=0) in HOLD, RELEASE or RUN: on the next edge, o_rst=all ones and o_ready=0.
  - o_loss_cnt increments only for a loss in RELEASE or RUN, saturating at 2^CNT_W-1.
  - Next state is PLL_RST if AUTO_RELOCK=1, else WAIT_LOCK.
- Simultaneous lock loss and final release in RELEASE: loss wins. o_ready stays 0 and the count increments.
- NUM_RST=1: o_ready asserts on the RELEASE entry cycle.
- Counters are sized with $clog2 of their maximum. No wrap occurs inside a state.

Test Plan:
1. Defaults, i_locked=1 throughout, i_rst high for 3 cycles then low. Take cycle 0 as the first edge with i_rst=0.
   - o_pll_rst=1 during cycles 0-7.
   - WAIT_LOCK at cycle 8, FILTER cycles 9-24, HOLD cycles 25-34.
   - o_rst[0]=0 from cycle 35, o_rst[1] from 39, o_rst[2] from 43, o_rst[3] from 47.
   - o_ready=1 from 47.
2. Lock glitch in FILTER: i_locked low for 1 cycle at filter count 10.
   - Sequence returns to WAIT_LOCK and the filter restarts from 0.
   - o_loss_cnt stays 0 and all o_rst stay 1.
3. Lock loss in RUN with AUTO_RELOCK=1.
   - SYNC_STAGES+1 cycles after i_locked falls: o_rst=4'hF, o_ready=0, o_loss_cnt=1.
   - o_pll_rst then pulses for 8 cycles, then the full sequence repeats.
4. AUTO_RELOCK=0, lock loss in RELEASE after o_rst[0] has cleared.
   - o_rst returns to 4'hF, o_pll_rst stays 0, state is WAIT_LOCK, o_loss_cnt=1.
5. CNT_W=2: force 5 losses in RUN -> o_loss_cnt saturates at 3.
6. i_rst asserted while state is RELEASE with o_rst=4'b1100.
   - Next edge: o_rst=4'hF, o_pll_rst=1, o_ready=0, o_loss_cnt=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock through a synchroniser
// and stability filter, then releases NUM_RST reset domains in a staggered order.
module pll_reset_sequencer #(
   parameter int NUM_RST        = 4,
   parameter int RST_CYCLES     = 10,
   parameter int STAGGER        = 4,
   parameter int LOCK_FILTER    = 16,
   parameter int PLL_RST_CYCLES = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int AUTO_RELOCK    = 1,
   parameter int CNT_W          = 8
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_locked,
   output logic               o_pll_rst,
   output logic [NUM_RST-1:0] o_rst,
   output logic               o_ready,
   output logic [CNT_W-1:0]   o_loss_cnt
);

   localparam int REL_MAX = STAGGER * (NUM_RST - 1);
   localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_FILTER) ? PLL_RST_CYCLES : LOCK_FILTER;
   localparam int MAX_B   = (RST_CYCLES > REL_MAX) ? RST_CYCLES : REL_MAX;
   localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES);
   localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILTER - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST  = CW'(REL_MAX);

   typedef enum logic [2:0] {
      ST_PLL_RST,
      ST_WAIT_LOCK,
      ST_FILTER,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic               pll_rst_q, pll_rst_d;
   logic [NUM_RST-1:0] rst_q, rst_d;
   logic               ready_q, ready_d;
   logic [CNT_W-1:0]   loss_q, loss_d;
   logic               lock_s;
   logic               lost;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], i_locked};
   assign lock_s = sync_q[SYNC_STAGES-1];

   assign o_pll_rst  = pll_rst_q;
   assign o_rst      = rst_q;
   assign o_ready    = ready_q;
   assign o_loss_cnt = loss_q;

   always_comb begin
      state_d   = state_q;
      cnt_inc   = cnt_q + 1'b1;
      cnt_d     = cnt_q;
      pll_rst_d = pll_rst_q;
      rst_d     = rst_q;
      ready_d   = ready_q;
      loss_d    = loss_q;
      lost      = 1'b0;

      unique case (state_q)
         // The reset-exit path starts the count at 0 and the loss path at 1, so both
         // give a pulse of exactly PLL_RST_CYCLES non-reset cycles.
         ST_PLL_RST: begin
            if (cnt_q == PLL_LAST) begin
               state_d   = ST_WAIT_LOCK;
               cnt_d     = '0;
               pll_rst_d = 1'b0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_d = ST_FILTER;
               cnt_d   = '0;
            end
         end
         ST_FILTER: begin
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == FILT_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_HOLD: begin
            if (!lock_s) begin
               lost = 1'b1;
            end else if (cnt_q == HOLD_LAST) begin
               cnt_d    = '0;
               rst_d[0] = 1'b0;
               if (NUM_RST == 1) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end else begin
                  state_d = ST_RELEASE;
               end
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ST_RELEASE: begin
            if (!lock_s) begin
               lost = 1'b1;
            end else begin
               cnt_d = cnt_inc;
               for (int k = 1; k < NUM_RST; k++) begin
                  if (cnt_inc == CW'(STAGGER * k)) rst_d[k] = 1'b0;
               end
               if (cnt_inc == REL_LAST) begin
                  state_d = ST_RUN;
                  ready_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (!lock_s) lost = 1'b1;
         end
         default: begin
            state_d   = ST_PLL_RST;
            cnt_d     = '0;
            pll_rst_d = 1'b1;
            rst_d     = '1;
            ready_d   = 1'b0;
         end
      endcase

      // Loss takes priority over any release step decided above in the same cycle.
      if (lost) begin
         rst_d   = '1;
         ready_d = 1'b0;
         if (state_q != ST_HOLD && loss_q != '1) loss_d = loss_q + 1'b1;
         if (AUTO_RELOCK != 0) begin
            state_d   = ST_PLL_RST;
            pll_rst_d = 1'b1;
            cnt_d     = CW'(1);
         end else begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_PLL_RST;
         cnt_q     <= '0;
         sync_q    <= '0;
         pll_rst_q <= 1'b1;
         rst_q     <= '1;
         ready_q   <= 1'b0;
         loss_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sync_q    <= sync_d;
         pll_rst_q <= pll_rst_d;
         rst_q     <= rst_d;
         ready_q   <= ready_d;
         loss_q    <= loss_d;
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: three parameterisations share one stimulus stream and are
// checked every cycle against a timestamp-based reference model, plus directed spot checks.
module tb_pll_reset_sequencer;

   localparam int N    = 4;
   localparam int P    = 8;
   localparam int F    = 16;
   localparam int H    = 10;
   localparam int S    = 4;
   localparam int SYNC = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_i, lk_i;
   logic       pll_a, rdy_a, pll_b, rdy_b, pll_c, rdy_c;
   logic [3:0] rst_a, rst_b, rst_c;
   logic [7:0] loss_a, loss_b;
   logic [1:0] loss_c;

   pll_reset_sequencer dut_a (
      .i_clk(clk), .i_rst(rst_i), .i_locked(lk_i),
      .o_pll_rst(pll_a), .o_rst(rst_a), .o_ready(rdy_a), .o_loss_cnt(loss_a)
   );

   pll_reset_sequencer #(.AUTO_RELOCK(0)) dut_b (
      .i_clk(clk), .i_rst(rst_i), .i_locked(lk_i),
      .o_pll_rst(pll_b), .o_rst(rst_b), .o_ready(rdy_b), .o_loss_cnt(loss_b)
   );

   pll_reset_sequencer #(.CNT_W(2)) dut_c (
      .i_clk(clk), .i_rst(rst_i), .i_locked(lk_i),
      .o_pll_rst(pll_c), .o_rst(rst_c), .o_ready(rdy_c), .o_loss_cnt(loss_c)
   );

   int total = 0;
   int bad   = 0;
   int edge_n = 0;

   logic [13:0] exp_a[$];
   logic [13:0] exp_b[$];
   logic [13:0] exp_c[$];

   // Reference model: lock history as a delay line, phases as timestamps of the edge
   // where the pulse started and where lock qualification started.
   bit hist[$];
   bit m_pulsing[3];
   int m_pstart[3];
   int m_lstart[3];
   int m_cnt[3];
   int m_auto[3] = '{1, 0, 1};
   int m_cmax[3] = '{255, 255, 3};

   function automatic logic [13:0] model_out(input int i, input int n);
      logic [3:0] r;
      logic       rd;
      int         e;
      r  = 4'hF;
      rd = 1'b0;
      if (!m_pulsing[i] && m_lstart[i] >= 0) begin
         e = n - m_lstart[i];
         for (int k = 0; k < N; k++) if (e >= F + H + S * k) r[k] = 1'b0;
         rd = (e >= F + H + S * (N - 1));
      end
      return {m_pulsing[i], r, rd, 8'(m_cnt[i])};
   endfunction

   task automatic model_step(input bit r, input bit lk, input int n);
      bit s;
      int e;
      if (r) begin
         hist.delete();
         for (int j = 0; j < SYNC; j++) hist.push_back(1'b0);
         for (int i = 0; i < 3; i++) begin
            m_pulsing[i] = 1'b1;
            m_pstart[i]  = n + 1;
            m_lstart[i]  = -1;
            m_cnt[i]     = 0;
         end
      end else begin
         s = hist.pop_front();
         hist.push_back(lk);
         for (int i = 0; i < 3; i++) begin
            if (m_pulsing[i]) begin
               if (n - m_pstart[i] >= P) m_pulsing[i] = 1'b0;
            end else if (m_lstart[i] < 0) begin
               if (s) m_lstart[i] = n;
            end else if (!s) begin
               e = n - m_lstart[i];
               if (e > F) begin
                  if (e > F + H && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                  if (m_auto[i] != 0) begin
                     m_pulsing[i] = 1'b1;
                     m_pstart[i]  = n;
                  end
               end
               m_lstart[i] = -1;
            end
         end
      end
      exp_a.push_back(model_out(0, n));
      exp_b.push_back(model_out(1, n));
      exp_c.push_back(model_out(2, n));
   endtask

   task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at edge %0d: got %h expected %h", nm, edge_n, act, exp);
      end
   endtask

   task automatic tick(input bit r, input bit lk);
      rst_i = r;
      lk_i  = lk;
      model_step(r, lk, edge_n);
      edge_n++;
      @(negedge clk);
   endtask

   function automatic bit rnd_rst();
      return ($urandom_range(0, 599) == 0);
   endfunction

   always @(posedge clk) begin
      #1;
      if (exp_a.size() > 0) chk("dut_a", {pll_a, rst_a, rdy_a, loss_a}, exp_a.pop_front());
      if (exp_b.size() > 0) chk("dut_b", {pll_b, rst_b, rdy_b, loss_b}, exp_b.pop_front());
      if (exp_c.size() > 0) chk("dut_c", {pll_c, rst_c, rdy_c, 6'b0, loss_c}, exp_c.pop_front());
   end

   initial begin
      bit found;
      int start;
      int len;

      // Power-up sequence with lock held high
      repeat (3) tick(1'b1, 1'b1);
      chk("reset_state", {pll_a, rst_a, rdy_a, loss_a}, {1'b1, 4'hF, 1'b0, 8'd0});
      for (int c = 0; c < 60; c++) begin
         tick(1'b0, 1'b1);
         if (c == 7)  chk("t1_pll_c7",  14'(pll_a), 14'd1);
         if (c == 8)  chk("t1_pll_c8",  14'(pll_a), 14'd0);
         if (c == 34) chk("t1_rst_c34", 14'(rst_a), 14'hF);
         if (c == 35) chk("t1_rst_c35", 14'(rst_a), 14'hE);
         if (c == 38) chk("t1_rst_c38", 14'(rst_a), 14'hE);
         if (c == 39) chk("t1_rst_c39", 14'(rst_a), 14'hC);
         if (c == 43) chk("t1_rst_c43", 14'(rst_a), 14'h8);
         if (c == 46) chk("t1_rdy_c46", 14'(rdy_a), 14'd0);
         if (c == 47) chk("t1_rst_c47", 14'(rst_a), 14'h0);
         if (c == 47) chk("t1_rdy_c47", 14'(rdy_a), 14'd1);
      end

      // Lock loss in RUN
      repeat (3) tick(1'b0, 1'b0);
      chk("t3_rst",   14'(rst_a),  14'hF);
      chk("t3_rdy",   14'(rdy_a),  14'd0);
      chk("t3_loss",  14'(loss_a), 14'd1);
      chk("t3_pll",   14'(pll_a),  14'd1);
      chk("t3_pll_b", 14'(pll_b),  14'd0);
      chk("t3_loss_b", 14'(loss_b), 14'd1);
      for (int j = 1; j <= 8; j++) begin
         tick(1'b0, j > 1);
         if (j == 7) chk("t3_pll_j7", 14'(pll_a), 14'd1);
         if (j == 8) chk("t3_pll_j8", 14'(pll_a), 14'd0);
      end
      repeat (70) tick(1'b0, 1'b1);

      // One-cycle lock glitch during the filter
      repeat (3) tick(1'b1, 1'b1);
      for (int c = 0; c < 50; c++) begin
         tick(1'b0, c != 17);
         if (c == 24) chk("t2_loss",    14'(loss_a), 14'd0);
         if (c == 35) chk("t2_rst_c35", 14'(rst_a),  14'hF);
         if (c == 45) chk("t2_rst_c45", 14'(rst_a),  14'hF);
         if (c == 46) chk("t2_rst_c46", 14'(rst_a),  14'hE);
      end

      // Lock loss during RELEASE, no automatic relock on dut_b
      repeat (3) tick(1'b1, 1'b1);
      for (int c = 0; c < 100; c++) begin
         tick(1'b0, !(c >= 37 && c < 40));
         if (c == 38) chk("t4_rst_c38", 14'(rst_b), 14'hE);
         if (c == 39) begin
            chk("t4_rst_b",  14'(rst_b),  14'hF);
            chk("t4_pll_b",  14'(pll_b),  14'd0);
            chk("t4_loss_b", 14'(loss_b), 14'd1);
            chk("t4_pll_a",  14'(pll_a),  14'd1);
         end
      end

      // Five losses in RUN saturate the 2-bit counter
      repeat (3) tick(1'b1, 1'b1);
      repeat (5) begin
         repeat (65) tick(1'b0, 1'b1);
         repeat (4) tick(1'b0, 1'b0);
      end
      chk("t5_loss_a", 14'(loss_a), 14'd5);
      chk("t5_loss_b", 14'(loss_b), 14'd5);
      chk("t5_loss_c", 14'(loss_c), 14'd3);

      // Reset while partially released
      found = 1'b0;
      for (int j = 0; j < 100 && !found; j++) begin
         tick(1'b0, 1'b1);
         if (rst_a == 4'b1100) found = 1'b1;
      end
      chk("t6_reached_1100", 14'(found), 14'd1);
      tick(1'b1, 1'b1);
      chk("t6_rst",  14'(rst_a),  14'hF);
      chk("t6_pll",  14'(pll_a),  14'd1);
      chk("t6_rdy",  14'(rdy_a),  14'd0);
      chk("t6_loss", 14'(loss_a), 14'd0);

      // Random lock waveform with occasional resets
      start = edge_n;
      while (edge_n - start < 4000) begin
         len = $urandom_range(1, 90);
         repeat (len) tick(rnd_rst(), 1'b1);
         len = $urandom_range(1, 5);
         repeat (len) tick(rnd_rst(), 1'b0);
      end

      chk("queues_drained", 14'(exp_a.size() + exp_b.size() + exp_c.size()), 14'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
